// File: rtl/vendor_multi.sv
// rtl/vendor_multi.sv - distance-fare ticket vending controller with change and refund
// Optional 5-coin support is enabled by defining VENDOR_FIVE_COIN_EN.
module vendor_multi #(
    parameter int WIDTH     = 8,
    parameter int STATIONS  = 32,
    parameter int HOME      = 16,
    parameter int BASE_FARE = 1,
    parameter int STEP_FARE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dest,
    input  logic [WIDTH-1:0] count,
    input  logic             coin_1,
    input  logic             coin_5,
    input  logic             coin_10,
    input  logic             done,
    input  logic             cancel,
    output logic             ticket,
    output logic             one_output,
    output logic             five_output,
    output logic             ten_output,
    output logic [WIDTH-1:0] credit,
    output logic             busy,
    output logic             short,
    output logic             err
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] HOME_W     = WIDTH'(HOME);
    localparam logic [W2-1:0]    STATIONS_W = W2'(STATIONS);
    localparam logic [W2-1:0]    BASE_W     = W2'(BASE_FARE);
    localparam logic [W2-1:0]    STEP_W     = W2'(STEP_FARE);
    localparam logic [WIDTH-1:0] C1         = WIDTH'(1);
    localparam logic [WIDTH-1:0] C5         = WIDTH'(5);
    localparam logic [WIDTH-1:0] C10        = WIDTH'(10);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_CHANGE = 2'd2} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_credit, w_credit_nxt;
    logic [WIDTH-1:0] r_remaining, w_remaining_nxt;
    logic             r_done_q;
    logic             r_ticket, r_one, r_five, r_ten, r_busy, r_short, r_err;
    logic             w_ticket_nxt, w_one_nxt, w_five_nxt, w_ten_nxt;
    logic             w_busy_nxt, w_short_nxt, w_err_nxt;

`ifdef VENDOR_FIVE_COIN_EN
    localparam bit FIVE_EN = 1'b1;
    logic w_coin_5;
    assign w_coin_5 = coin_5;
`else
    localparam bit FIVE_EN = 1'b0;
    logic w_coin_5;
    logic w_unused_coin_5;
    assign w_coin_5        = 1'b0;
    assign w_unused_coin_5 = coin_5;
`endif

    logic [WIDTH:0]   w_coin_sum, w_credit_add;
    logic             w_overflow;
    logic [WIDTH-1:0] w_credit_in;
    logic [WIDTH-1:0] w_dist;
    logic [W2-1:0]    w_fare, w_total;
    logic             w_done_edge, w_invalid, w_no_funds;

    // One extra bit catches a coin sum that would wrap the credit register.
    assign w_coin_sum   = (coin_1   ? (WIDTH+1)'(1)  : '0)
                        + (w_coin_5 ? (WIDTH+1)'(5)  : '0)
                        + (coin_10  ? (WIDTH+1)'(10) : '0);
    assign w_credit_add = {1'b0, r_credit} + w_coin_sum;
    assign w_overflow   = w_credit_add[WIDTH];
    assign w_credit_in  = w_overflow ? r_credit : w_credit_add[WIDTH-1:0];

    assign w_dist      = (dest >= HOME_W) ? (dest - HOME_W) : (HOME_W - dest);
    assign w_fare      = BASE_W + STEP_W * W2'(w_dist);
    assign w_total     = w_fare * W2'(count);
    assign w_done_edge = done & ~r_done_q;
    assign w_invalid   = (W2'(dest) >= STATIONS_W) || (count == '0);
    assign w_no_funds  = w_total > W2'(w_credit_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_credit    <= '0;
            r_remaining <= '0;
            r_done_q    <= 1'b0;
            r_ticket    <= 1'b0;
            r_one       <= 1'b0;
            r_five      <= 1'b0;
            r_ten       <= 1'b0;
            r_busy      <= 1'b0;
            r_short     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_remaining <= w_remaining_nxt;
            r_done_q    <= done;
            r_ticket    <= w_ticket_nxt;
            r_one       <= w_one_nxt;
            r_five      <= w_five_nxt;
            r_ten       <= w_ten_nxt;
            r_busy      <= w_busy_nxt;
            r_short     <= w_short_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cancel)
                    w_state_nxt = S_CHANGE;
                else if (w_done_edge && !w_invalid && !w_no_funds)
                    w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_remaining <= C1)
                    w_state_nxt = S_CHANGE;
            end
            S_CHANGE: begin
                if (r_credit == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_credit_nxt    = r_credit;
        w_remaining_nxt = r_remaining;
        w_ticket_nxt    = 1'b0;
        w_one_nxt       = 1'b0;
        w_five_nxt      = 1'b0;
        w_ten_nxt       = 1'b0;
        w_short_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_busy_nxt      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_credit_nxt = w_credit_in;
                // Rejected coins go straight back out of their own chute.
                if (w_overflow) begin
                    w_one_nxt  = coin_1;
                    w_five_nxt = w_coin_5;
                    w_ten_nxt  = coin_10;
                end
                if (!cancel && w_done_edge) begin
                    if (w_invalid)
                        w_err_nxt = 1'b1;
                    else if (w_no_funds)
                        w_short_nxt = 1'b1;
                    else begin
                        w_credit_nxt    = w_credit_in - w_total[WIDTH-1:0];
                        w_remaining_nxt = count;
                    end
                end
            end
            S_ISSUE: begin
                w_ticket_nxt    = 1'b1;
                w_remaining_nxt = r_remaining - C1;
            end
            S_CHANGE: begin
                if (r_credit >= C10) begin
                    w_ten_nxt    = 1'b1;
                    w_credit_nxt = r_credit - C10;
                end else if (FIVE_EN && (r_credit >= C5)) begin
                    w_five_nxt   = 1'b1;
                    w_credit_nxt = r_credit - C5;
                end else if (r_credit >= C1) begin
                    w_one_nxt    = 1'b1;
                    w_credit_nxt = r_credit - C1;
                end
            end
            default: ;
        endcase
    end

    assign ticket      = r_ticket;
    assign one_output  = r_one;
    assign five_output = r_five;
    assign ten_output  = r_ten;
    assign credit      = r_credit;
    assign busy        = r_busy;
    assign short       = r_short;
    assign err         = r_err;
endmodule

// File: doc/vendor_multi.md
# vendor_multi

Parametrised ticket vending controller for the fare-gate subsystem, succeeding the single-fare vendor. It accepts 1/5/10 coins and computes a distance-based fare from a home station. It issues tickets one pulse per cycle, then dispenses change greedily one coin per cycle. Adds cancel/refund, insufficient-funds and invalid-request flags, overflow coin return and a busy indication.

## Interface
- WIDTH, 8: width of dest, count, credit and fare arithmetic.
- STATIONS, 32: number of valid stations; dest range 0..STATIONS-1.
- HOME, 16: station index of this machine.
- BASE_FARE, 1: fare for distance 0.
- STEP_FARE, 1: fare added per station of distance.
- clk  input  1  clock.
- rst  input  1  reset; one clock, synchronous, active-high.
- dest  input  WIDTH  destination station; sampled on the done rising edge.
- count  input  WIDTH  tickets requested; sampled on the done rising edge.
- coin_1, coin_5, coin_10  input  1 each  each high cycle inserts one coin of that value.
- done  input  1  purchase request; only its rising edge acts.
- cancel  input  1  refund all credit (level, acted on in IDLE).
- ticket  output  1  one pulse per issued ticket.
- one_output, five_output, ten_output  output  1 each  one pulse per dispensed coin.
- credit  output  WIDTH  current credit.
- busy  output  1  high outside IDLE.
- short  output  1  one-cycle pulse: funds insufficient.
- err  output  1  one-cycle pulse: invalid request.

## Operation
- States: IDLE, ISSUE, CHANGE.
- Fare per ticket: BASE_FARE + STEP_FARE*|dest-HOME|. Total = fare*count, computed at 2*WIDTH bits with no truncation.
- IDLE, coins:
  - credit += sum of coins inserted this cycle.
  - If the sum would exceed 2^WIDTH-1, all of this cycle's coins are rejected: credit is unchanged, and each rejected coin pulses its matching *_output on the next cycle.
- IDLE, priority cancel > done-edge > coins. Coins arriving in the same cycle as cancel or a done edge are still credited before that action.
- cancel → CHANGE.
- done rising edge:
  - dest >= STATIONS or count == 0 → err pulse; stay IDLE; credit kept.
  - total > credit → short pulse; stay IDLE; credit kept.
  - Otherwise credit -= total; remaining tickets = count; → ISSUE.
- ISSUE: ticket=1 each cycle, decrementing remaining tickets; after the last ticket → CHANGE.
- CHANGE, one coin per cycle, largest first:
  - credit >= 10 → ten_output, credit -= 10.
  - else credit >= 5 → five_output, credit -= 5.
  - else credit >= 1 → one_output, credit -= 1.
  - credit == 0 → IDLE, no pulse.
- Coins and done are ignored (not credited, not returned) outside IDLE. cancel is ignored outside IDLE.
- Done edge detector register is updated every cycle in all states. A done held high across IDLE re-entry therefore does not retrigger.

## Timing
- Reset: state IDLE; credit 0; every output 0; done edge register 0. Reset mid-ISSUE/CHANGE aborts the transaction, and the undispensed credit is discarded.
- All outputs are registered.
- Done edge sampled at clock edge k: busy=1 and the first ticket are visible after edge k+1. Tickets occupy count consecutive cycles.
- The first change pulse follows the last ticket with no gap. The CHANGE exit cycle (credit 0) shows busy=1 and no pulse. busy falls on the following cycle.
- short/err: visible for exactly one cycle after edge k.
- cancel sampled at edge k: first refund pulse after edge k+1.
- Credit 0 on entry to CHANGE: one cycle in CHANGE, then IDLE.
- Coin credit is visible on credit one cycle after insertion. A rejected-coin return pulse is visible one cycle after insertion.

## Configuration
- VENDOR_FIVE_COIN_EN defined: coin_5 is accepted, and 5 is used in change.
- VENDOR_FIVE_COIN_EN undefined:
  - coin_5 is ignored entirely (not credited, not returned).
  - five_output is constant 0.
  - Change uses 10 then 1 only.

## Test plan
- Reset: rst high 2 cycles with coins toggling → all outputs 0, credit 0, busy 0; then coin_1 once → credit 1.
- Purchase: dest 15, count 3, coin_1, coin_1, coin_10 → credit 12; done edge → 3 ticket pulses. Then five_output, one_output with macro (six one_output pulses without). Then IDLE, credit 0. done held 2 cycles → still 3 tickets.
- Short: dest 10, count 2 (total 14), credit 10, done edge → short 1 cycle, no ticket, credit 10, busy 0.
- Invalid: dest 40 or count 0, done edge → err 1 cycle, credit unchanged.
- Cancel: credit 17, cancel → ten, five, one, one over 4 consecutive cycles, then busy 0, credit 0.
- Overflow: credit 250, coin_10 → credit stays 250, ten_output pulse next cycle. Reset asserted mid-CHANGE → outputs 0 next cycle, credit 0.
